// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle data-memory responder (load/store with lane merge)
// Revision : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic          commit;
  logic          request;

  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_wdata;
  logic [1:0]    cap_size;
  logic          cap_write;

  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_write;
  logic [AW-1:0] word_idx;
  logic          acc_mis;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic [31:0]   load_val;

  logic [31:0]   mem [DEPTH];

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[31:AW+2];

  assign request = MemRead | MemWrite;
  assign Stall   = ~Reset & (((state == IDLE) & request) | (state == WAIT));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY == 1 the commit happens on the accepting edge, so the live
  // request fields must be used instead of the (not yet loaded) captured ones.
  always_comb begin
    acc_addr  = (state == IDLE) ? Address[AW+1:0] : cap_addr;
    acc_wdata = (state == IDLE) ? WriteData       : cap_wdata;
    acc_size  = (state == IDLE) ? Size            : cap_size;
    acc_write = (state == IDLE) ? MemWrite        : cap_write;
    word_idx  = acc_addr[AW+1:2];
    old_word  = mem[word_idx];

    case (acc_size)
      2'b00:   acc_mis = (acc_addr[1:0] != 2'b00);
      2'b01:   acc_mis = acc_addr[0];
      2'b10:   acc_mis = 1'b0;
      default: acc_mis = 1'b1;
    endcase

    merged   = old_word;
    load_val = old_word;
    case (acc_size)
      2'b01: begin
        merged[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
        load_val = {16'h0000, old_word[{acc_addr[1], 4'b0000} +: 16]};
      end
      2'b10: begin
        merged[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
        load_val = {24'h000000, old_word[{acc_addr[1:0], 3'b000} +: 8]};
      end
      default: merged = acc_wdata;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_size   <= 2'b00;
      cap_write  <= 1'b0;
      Done       <= 1'b0;
      ReadData   <= '0;
      Misaligned <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      Done       <= commit;
      Misaligned <= commit & acc_mis;
      ReadData   <= (commit && !acc_mis && !acc_write) ? load_val : 32'h0;
      if (state == IDLE && request) begin
        cap_addr  <= Address[AW+1:0];
        cap_wdata <= WriteData;
        cap_size  <= Size;
        cap_write <= MemWrite;
      end
      if (commit && acc_write && !acc_mis) begin
        mem[word_idx] <= merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench; instances at LATENCY 2, 4 and 1
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst   [3];
  logic        mrd   [3];
  logic        mwr   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [1:0]  size  [3];
  logic        stall [3];
  logic        done  [3];
  logic [31:0] rdata [3];
  logic        mis_o [3];

  int lat_of [3] = '{2, 4, 1};
  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_lat2 (
    .Clk(clk), .Reset(rst[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .Address(addr[0]), .WriteData(wdata[0]), .Size(size[0]),
    .Stall(stall[0]), .Done(done[0]), .ReadData(rdata[0]), .Misaligned(mis_o[0])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_lat4 (
    .Clk(clk), .Reset(rst[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .Address(addr[1]), .WriteData(wdata[1]), .Size(size[1]),
    .Stall(stall[1]), .Done(done[1]), .ReadData(rdata[1]), .Misaligned(mis_o[1])
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
    .Clk(clk), .Reset(rst[2]), .MemRead(mrd[2]), .MemWrite(mwr[2]),
    .Address(addr[2]), .WriteData(wdata[2]), .Size(size[2]),
    .Stall(stall[2]), .Done(done[2]), .ReadData(rdata[2]), .Misaligned(mis_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Presents one request, waits (bounded) for Done, checks the Stall window.
  task automatic access(input int u, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input string tag,
                        output logic [31:0] rv, output logic mv);
    int stalls;
    bit seen;
    stalls = 0;
    seen   = 1'b0;
    rv     = '0;
    mv     = 1'b0;
    mwr[u] = wr; mrd[u] = rd; addr[u] = a; wdata[u] = d; size[u] = sz;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done[u]) begin
        seen = 1'b1;
        rv   = rdata[u];
        mv   = mis_o[u];
        check({tag, "/stall_in_resp"}, 32'(stall[u]), 32'd0);
      end else if (stall[u]) begin
        stalls++;
      end
    end
    mwr[u] = 1'b0;
    mrd[u] = 1'b0;
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/stall_cycles"}, 32'(stalls), 32'(lat_of[u]));
    @(posedge clk); #1;
  endtask

  task automatic store(input int u, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit exp_mis, input string tag);
    logic [31:0] rv;
    logic        mv;
    access(u, 1'b1, 1'b0, a, d, sz, tag, rv, mv);
    check({tag, "/misaligned"}, 32'(mv), 32'(exp_mis));
    if (exp_mis) check({tag, "/rdata_zero"}, rv, 32'h0);
  endtask

  task automatic load_chk(input int u, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] exp, input bit exp_mis, input string tag);
    logic [31:0] rv;
    logic        mv;
    access(u, 1'b0, 1'b1, a, 32'h0, sz, tag, rv, mv);
    check({tag, "/rdata"}, rv, exp);
    check({tag, "/misaligned"}, 32'(mv), 32'(exp_mis));
  endtask

  initial begin
    int          n_done;
    logic [7:0]  done_pat;
    logic [7:0]  stall_pat;
    logic [31:0] b2b_data;
    logic [31:0] rv;
    logic        mv;

    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; mrd[u] = 1'b0; mwr[u] = 1'b0;
      addr[u] = '0; wdata[u] = '0; size[u] = 2'b00;
    end
    mrd[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset/stall", 32'(stall[0]), 32'd0);
    check("reset/done", 32'(done[0]), 32'd0);
    check("reset/rdata", rdata[0], 32'h0);
    check("reset/misaligned", 32'(mis_o[0]), 32'd0);
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;
    mrd[0] = 1'b0;
    @(negedge clk);
    check("idle/stall", 32'(stall[0]), 32'd0);
    @(posedge clk); #1;

    // Word round trip
    store(0, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, "word_st");
    load_chk(0, 32'h10, 2'b00, 32'hDEADBEEF, 1'b0, "word_ld");

    // Byte/half merge
    store(0, 32'h20, 32'h11223344, 2'b00, 1'b0, "merge_w");
    store(0, 32'h21, 32'h000000AA, 2'b10, 1'b0, "merge_b");
    store(0, 32'h22, 32'h0000BEEF, 2'b01, 1'b0, "merge_h");
    load_chk(0, 32'h20, 2'b00, 32'hBEEFAA44, 1'b0, "merge_ld_w");
    load_chk(0, 32'h23, 2'b10, 32'h000000BE, 1'b0, "merge_ld_b3");
    load_chk(0, 32'h20, 2'b01, 32'h0000AA44, 1'b0, "merge_ld_h0");
    load_chk(0, 32'h22, 2'b01, 32'h0000BEEF, 1'b0, "merge_ld_h1");
    load_chk(0, 32'h21, 2'b10, 32'h000000AA, 1'b0, "merge_ld_b1");

    // Misalignment
    store(0, 32'h30, 32'h55667788, 2'b00, 1'b0, "mis_init");
    store(0, 32'h31, 32'h0000FFFF, 2'b01, 1'b1, "mis_half_st");
    load_chk(0, 32'h32, 2'b00, 32'h0, 1'b1, "mis_word_ld");
    store(0, 32'h30, 32'h00000000, 2'b11, 1'b1, "mis_size3_st");
    load_chk(0, 32'h30, 2'b11, 32'h0, 1'b1, "mis_size3_ld");
    load_chk(0, 32'h30, 2'b00, 32'h55667788, 1'b0, "mis_after");

    // Reset in the second WAIT cycle, LATENCY 4
    mwr[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h12345678; size[1] = 2'b00;
    @(negedge clk);
    check("rst_mid/stall_accept", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid/stall_wait1", 32'(stall[1]), 32'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    mwr[1] = 1'b0;
    @(negedge clk);
    check("rst_mid/stall_in_reset", 32'(stall[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done[1]) n_done++;
      if (i == 0) check("rst_mid/stall_after", 32'(stall[1]), 32'd0);
      @(posedge clk); #1;
    end
    check("rst_mid/no_done", 32'(n_done), 32'd0);
    load_chk(1, 32'h40, 2'b00, 32'h0, 1'b0, "rst_mid/ld");

    // LATENCY 1: simultaneous read+write counts as store, then back-to-back loads
    access(2, 1'b1, 1'b1, 32'h8, 32'h0BADF00D, 2'b00, "both_rw", rv, mv);
    check("both_rw/misaligned", 32'(mv), 32'd0);
    load_chk(2, 32'h8, 2'b00, 32'h0BADF00D, 1'b0, "both_rw/ld");
    mrd[2] = 1'b1; addr[2] = 32'h8; size[2] = 2'b00;
    done_pat  = '0;
    stall_pat = '0;
    b2b_data  = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done_pat[i]  = done[2];
      stall_pat[i] = stall[2];
      if (done[2]) b2b_data = rdata[2];
      if (i == 7) mrd[2] = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b/done_pattern", 32'(done_pat), 32'h000000AA);
    check("b2b/stall_pattern", 32'(stall_pat), 32'h00000055);
    check("b2b/rdata", b2b_data, 32'h0BADF00D);

    // Wrap-around at 4*DEPTH bytes
    store(0, 32'h1000, 32'hCAFEF00D, 2'b00, 1'b0, "wrap_st");
    load_chk(0, 32'h0000, 2'b00, 32'hCAFEF00D, 1'b0, "wrap_ld");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
